// File: rtl/uart_bus_master.sv
// UART command-frame parser that issues single-word reads/writes on the data-memory bus and replies with ack/data bytes.
// Optional XOR checksum on frames and read data: define UART_BUS_MASTER_CHECKSUM_EN.
module uart_bus_master #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDRESS_BITS = 64,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      bus_read,
    output logic                      bus_write,
    output logic [DATA_WIDTH/8-1:0]   bus_byte_en,
    output logic [ADDRESS_BITS-1:0]   bus_address,
    output logic [DATA_WIDTH-1:0]     bus_write_data,
    input  logic [DATA_WIDTH-1:0]     bus_read_data,
    input  logic                      bus_valid,
    output logic                      busy
);
    localparam int NA   = ADDRESS_BITS / 8;
    localparam int ND   = DATA_WIDTH / 8;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(NMAX + 2);
    localparam int TW   = $clog2(BUS_TIMEOUT + 1);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    localparam int TX_LAST = ND;       // data bytes plus trailing checksum byte
`else
    localparam int TX_LAST = ND - 1;
`endif
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        S_CHK,
`endif
        S_BUS,
        S_WAIT,
        S_RESP_ACK,
        S_RESP_DATA
    } state_t;

    state_t                  state, next;
    logic                    is_write;
    logic [CW-1:0]           cnt;
    logic [TW-1:0]           tmo;
    logic [ADDRESS_BITS-1:0] addr_sr, addr_shift;
    logic [DATA_WIDTH-1:0]   data_sr, data_shift, rdata_sr;
    logic [7:0]              ack_code, ack_val;
    logic                    ack_set, load_bus, tx_fire;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    logic [7:0]              csum, rsum;
`endif

    // Fields arrive LSB first, so each new byte enters at the top and slides down.
    assign addr_shift = (addr_sr >> 8) | (ADDRESS_BITS'(rx_data) << (ADDRESS_BITS - 8));
    assign data_shift = (data_sr >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));

    assign busy        = (state != S_IDLE);
    assign bus_read    = (state == S_BUS) && !is_write;
    assign bus_write   = (state == S_BUS) && is_write;
    assign bus_byte_en = {ND{state == S_BUS}};
    assign tx_valid    = (state == S_RESP_ACK) || (state == S_RESP_DATA);
    assign tx_fire     = tx_valid && tx_ready;

    always_comb begin
        tx_data = 8'h00;
        if (state == S_RESP_ACK)
            tx_data = ack_code;
        else if (state == S_RESP_DATA) begin
            tx_data = rdata_sr[7:0];
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            if (cnt == CW'(ND))
                tx_data = rsum;
`endif
        end
    end

    always_comb begin
        next     = state;
        ack_set  = 1'b0;
        ack_val  = ACK_OK;
        load_bus = 1'b0;
        case (state)
            S_IDLE: if (rx_valid) begin
                if (rx_data == CMD_WR || rx_data == CMD_RD)
                    next = S_ADDR;
                else begin
                    next    = S_RESP_ACK;
                    ack_set = 1'b1;
                    ack_val = ACK_ERR;
                end
            end
            S_ADDR: if (rx_valid && cnt == CW'(NA - 1)) begin
                if (is_write)
                    next = S_DATA;
                else begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    next = S_CHK;
`else
                    next     = S_BUS;
                    load_bus = 1'b1;
`endif
                end
            end
            S_DATA: if (rx_valid && cnt == CW'(ND - 1)) begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                next = S_CHK;
`else
                next     = S_BUS;
                load_bus = 1'b1;
`endif
            end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            S_CHK: if (rx_valid) begin
                if (rx_data == csum) begin
                    next     = S_BUS;
                    load_bus = 1'b1;
                end else begin
                    next    = S_RESP_ACK;
                    ack_set = 1'b1;
                    ack_val = ACK_ERR;
                end
            end
`endif
            S_BUS: begin
                if (is_write) begin
                    next    = S_RESP_ACK;
                    ack_set = 1'b1;
                end else
                    next = S_WAIT;
            end
            S_WAIT: begin
                // A response landing on the final count still counts as success.
                if (bus_valid) begin
                    next    = S_RESP_ACK;
                    ack_set = 1'b1;
                end else if (tmo == TW'(BUS_TIMEOUT)) begin
                    next    = S_RESP_ACK;
                    ack_set = 1'b1;
                    ack_val = ACK_ERR;
                end
            end
            S_RESP_ACK: if (tx_fire)
                next = (!is_write && ack_code == ACK_OK) ? S_RESP_DATA : S_IDLE;
            S_RESP_DATA: if (tx_fire && cnt == CW'(TX_LAST))
                next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            is_write       <= 1'b0;
            cnt            <= '0;
            tmo            <= '0;
            addr_sr        <= '0;
            data_sr        <= '0;
            rdata_sr       <= '0;
            ack_code       <= 8'h00;
            bus_address    <= '0;
            bus_write_data <= '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            csum           <= 8'h00;
            rsum           <= 8'h00;
`endif
        end else begin
            state <= next;
            case (state)
                S_IDLE: if (rx_valid) begin
                    is_write <= (rx_data == CMD_WR);
                    cnt      <= '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    csum     <= rx_data;
`endif
                end
                S_ADDR: if (rx_valid) begin
                    addr_sr <= addr_shift;
                    cnt     <= (cnt == CW'(NA - 1)) ? '0 : cnt + CW'(1);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    csum    <= csum ^ rx_data;
`endif
                end
                S_DATA: if (rx_valid) begin
                    data_sr <= data_shift;
                    cnt     <= cnt + CW'(1);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    csum    <= csum ^ rx_data;
`endif
                end
                S_BUS:  tmo <= '0;
                S_WAIT: begin
                    tmo <= tmo + TW'(1);
                    if (bus_valid)
                        rdata_sr <= bus_read_data;
                end
                S_RESP_ACK: begin
                    cnt <= '0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    rsum <= 8'h00;
`endif
                end
                S_RESP_DATA: if (tx_fire) begin
                    rdata_sr <= rdata_sr >> 8;
                    cnt      <= cnt + CW'(1);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                    rsum     <= rsum ^ rdata_sr[7:0];
`endif
                end
                default: ;
            endcase
            if (ack_set)
                ack_code <= ack_val;
            // The final byte may still be on rx this cycle, so take it from the shifter.
            if (load_bus) begin
                bus_address <= (state == S_ADDR) ? addr_shift : addr_sr;
                if (is_write)
                    bus_write_data <= (state == S_DATA) ? data_shift : data_sr;
            end
        end
    end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Byte-stream-to-memory-bus initiator for the debug/loader path. It parses command frames arriving from the UART receive byte stream and issues single-word reads or writes on the shared data-memory bus, the same request/valid bus that BRAM, timer, UART and software-interrupt responders decode. It returns an acknowledge byte, plus read data, on the UART transmit byte stream. Used to load programs and peek/poke memory-mapped registers without the core.

## Interface
Parameters:
- DATA_WIDTH, 64, bus word width; multiple of 8
- ADDRESS_BITS, 64, bus address width; multiple of 8
- BUS_TIMEOUT, 255, max cycles to wait for bus_valid after a read strobe; must be at least 1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- bus_read  out  1  single-cycle read strobe
- bus_write  out  1  single-cycle write strobe
- bus_byte_en  out  DATA_WIDTH/8  all ones during a strobe, else 0
- bus_address  out  ADDRESS_BITS  request address
- bus_write_data  out  DATA_WIDTH  write data
- bus_read_data  in  DATA_WIDTH  read data, sampled when bus_valid
- bus_valid  in  1  read response valid
- busy  out  1  high in any state other than IDLE

## Operation
- Frame format, little-endian multi-byte fields. CMD byte: 0x57 write, 0x52 read. Then A = ADDRESS_BITS/8 address bytes. Write frames then carry D = DATA_WIDTH/8 data bytes.
- States: IDLE, ADDR, DATA, CHK (macro only), BUS, WAIT, RESP_ACK, RESP_DATA.
- IDLE: byte 0x57/0x52 latches command, clears byte counter, goes to ADDR. Any other byte goes to RESP_ACK with error code 0x45.
- ADDR: shift in A bytes. Then write goes to DATA; read goes to BUS (or CHK).
- DATA: shift in D bytes, then BUS (or CHK).
- BUS: one cycle. Assert bus_read or bus_write with byte_en all ones.
  - Write goes to RESP_ACK with code 0x4B; there is no write response.
  - Read goes to WAIT.
- WAIT: on bus_valid, capture bus_read_data and go to RESP_ACK with code 0x4B. If the counter reaches BUS_TIMEOUT without bus_valid, go to RESP_ACK with code 0x45.
- RESP_ACK: present the code on tx. On handshake:
  - successful read goes to RESP_DATA;
  - otherwise goes to IDLE.
- RESP_DATA: send D captured bytes, LSB first, then IDLE.
- rx bytes received outside IDLE/ADDR/DATA/CHK are dropped silently.
- bus_valid outside WAIT is ignored.
- bus_address/bus_write_data hold their last values between strobes.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame or mid-response aborts immediately; no strobe is issued and partial tx bytes are dropped.
- Strobe asserts in the cycle after the final frame byte is accepted (after CHK when the macro is on).
- Read: capture occurs in the bus_valid cycle. tx_valid with 0x4B rises the following cycle. A 1-cycle-latency responder gives strobe→ack = 2 cycles.
- Timeout counter starts at 0 in the first WAIT cycle. Error code 0x45 is issued when the count equals BUS_TIMEOUT.
- If bus_valid and timeout coincide, bus_valid wins.
- tx_data/tx_valid are stable while tx_valid && !tx_ready. Back-to-back bytes are allowed on consecutive handshake cycles.

## Configuration
- UART_BUS_MASTER_CHECKSUM_EN defined:
  - Each frame ends with one extra byte, CHK state. Its value is the XOR of all prior frame bytes, CMD included.
  - On mismatch: no bus strobe; RESP_ACK with 0x45.
  - A read response's data bytes are followed by an XOR checksum of the data bytes. That byte is not covered by the ack byte.
- Undefined: CHK state and checksum bytes do not exist; frames are CMD+address(+data) only.

## Test plan
- Write frame 0x57, addr 0x100, data 0x1122334455667788 → one bus_write cycle with address 0x100, data 0x1122334455667788, byte_en 0xFF; tx 0x4B only.
- Read frame 0x52, addr 0x100, responder returning 0xA5A5_0000_0000_5A5A after 1 cycle → tx 0x4B, 5A, 5A, 00, 00, 00, 00, A5, A5.
- Read with bus_valid never asserted, BUS_TIMEOUT=255 → tx 0x45 after 256 WAIT cycles, then IDLE; next frame is processed normally.
- Invalid CMD 0x33 → tx 0x45, no bus strobe. tx_ready held low 10 cycles → tx_data stays 0x45 with tx_valid high throughout.
- Reset asserted after 3 address bytes → outputs 0 immediately; a fresh valid read frame afterwards completes correctly.
- With UART_BUS_MASTER_CHECKSUM_EN, write frame with wrong checksum byte → tx 0x45 and no bus_write. Correct checksum → write occurs and tx 0x4B.
